// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the serial add/sub unit.
// FSM encodings and counter sizing.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_digit.sv
// One-digit ripple adder built from full_adder cells.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);
  logic [DIGIT_W:0] c;

  assign c[0] = cin;
  assign cout = c[DIGIT_W];

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end
endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT_W bits per clock,
// LSB digit first, with a registered inter-digit carry.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             done
);
  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = cnt_w(N);
  localparam logic [WIDTH-1:0] DMASK =
    WIDTH'({DIGIT_W{1'b1}});

  if (WIDTH % DIGIT_W != 0) begin : g_chk
    $error("DIGIT_W must divide WIDTH");
  end

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_reg, b_reg, r_reg, r_nxt;
  logic               carry;
  logic [31:0]        base;
  logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
  logic               dig_cout;
  logic               last;
  logic               accept;

  assign base  = 32'(cnt) * 32'(DIGIT_W);
  assign a_dig = DIGIT_W'(a_reg >> base);
  assign b_dig = DIGIT_W'(b_reg >> base);
  assign last  = (cnt == CNT_W'(N - 1));

  adder_digit #(.DIGIT_W(DIGIT_W)) u_dig (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .s    (s_dig),
    .cout (dig_cout)
  );

  always_comb begin
    r_nxt = (r_reg & ~(DMASK << base))
          | (WIDTH'(s_dig) << base);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  assign accept = ready && start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      r_reg    <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_reg <= A;
      b_reg <= sub ? ~B : B;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (busy) begin
      r_reg <= r_nxt;
      carry <= dig_cout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        cout     <= dig_cout;
        zero     <= (r_nxt == '0);
        // b_reg is already inverted for subtract
        overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                 && (r_nxt[WIDTH-1] != a_reg[WIDTH-1]);
      end
    end
  end

  assign r = r_reg;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at DIGIT_W = 1, 8, 32.
// Vector table plus handshake and reset sequences.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sub, cin;
  logic [31:0] a, b;
  logic [2:0]  start_v;
  logic [31:0] r_o [3];
  logic [2:0]  ready_o, busy_o, cout_o;
  logic [2:0]  ovf_o, zero_o, done_o;

  serial_add_sub #(.WIDTH(32), .DIGIT_W(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .ready(ready_o[0]), .busy(busy_o[0]),
    .sub(sub), .cin(cin), .A(a), .B(b),
    .r(r_o[0]), .cout(cout_o[0]),
    .overflow(ovf_o[0]), .zero(zero_o[0]),
    .done(done_o[0])
  );

  serial_add_sub #(.WIDTH(32), .DIGIT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .ready(ready_o[1]), .busy(busy_o[1]),
    .sub(sub), .cin(cin), .A(a), .B(b),
    .r(r_o[1]), .cout(cout_o[1]),
    .overflow(ovf_o[1]), .zero(zero_o[1]),
    .done(done_o[1])
  );

  serial_add_sub #(.WIDTH(32), .DIGIT_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .ready(ready_o[2]), .busy(busy_o[2]),
    .sub(sub), .cin(cin), .A(a), .B(b),
    .r(r_o[2]), .cout(cout_o[2]),
    .overflow(ovf_o[2]), .zero(zero_o[2]),
    .done(done_o[2])
  );

  typedef struct {
    bit          s;
    bit          c;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] er;
    bit          ec;
    bit          eo;
    bit          ez;
  } vec_t;

  vec_t vecs [7];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // lat counts edges from the accepting edge inclusive
  // to the edge after which done is seen.
  task automatic run_op(input int d, input bit s, input bit c,
                        input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    sub = s; cin = c; a = x; b = y;
    start_v[d] = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 start_v[d] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_o[d]) break;
    end
  endtask

  task automatic wait_done(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done_o[d]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int lat;
  bit ok;
  int dcount;

  initial begin
    vecs[0] = '{0, 0, 32'hFFFFFFFF, 32'h1,
                32'h0, 1, 0, 1};
    vecs[1] = '{1, 0, 32'd5, 32'd7,
                32'hFFFFFFFE, 0, 0, 0};
    vecs[2] = '{1, 1, 32'd7, 32'd5,
                32'd2, 1, 0, 0};
    vecs[3] = '{0, 0, 32'h7FFFFFFF, 32'h1,
                32'h80000000, 0, 1, 0};
    vecs[4] = '{1, 0, 32'h80000000, 32'h1,
                32'h7FFFFFFF, 1, 1, 0};
    vecs[5] = '{0, 1, 32'h12345678, 32'h11111111,
                32'h2345678A, 0, 0, 0};
    vecs[6] = '{1, 0, 32'd5, 32'd5,
                32'h0, 1, 0, 1};

    rst_n = 1'b0; start_v = '0;
    sub = 0; cin = 0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", 64'(ready_o[0]), 1);
    check("rst_busy",  64'(busy_o[0]),  0);
    check("rst_done",  64'(done_o[0]),  0);
    check("rst_r",     64'(r_o[0]),     0);
    check("rst_flags", 64'({cout_o[0], ovf_o[0], zero_o[0]}), 0);

    for (int i = 0; i < 7; i++) begin
      run_op(0, vecs[i].s, vecs[i].c, vecs[i].x, vecs[i].y, lat);
      check($sformatf("v%0d_lat", i),  64'(lat), 33);
      check($sformatf("v%0d_r", i),    64'(r_o[0]), 64'(vecs[i].er));
      check($sformatf("v%0d_cout", i), 64'(cout_o[0]), 64'(vecs[i].ec));
      check($sformatf("v%0d_ovf", i),  64'(ovf_o[0]), 64'(vecs[i].eo));
      check($sformatf("v%0d_zero", i), 64'(zero_o[0]), 64'(vecs[i].ez));
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse", i), 64'(done_o[0]), 0);
      check($sformatf("v%0d_hold", i),  64'(r_o[0]), 64'(vecs[i].er));
    end

    // start during RUN must be ignored
    sub = 0; cin = 0; a = 32'd3; b = 32'd4;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 a = 32'd100; b = 32'd100; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    wait_done(0, ok);
    check("ign_done", 64'(ok), 1);
    check("ign_r", 64'(r_o[0]), 7);
    check("ign_busy", 64'(busy_o[0]), 0);

    // start held during DONE: back-to-back accept
    a = 32'd10; b = 32'd20; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    check("b2b_pulse", 64'(done_o[0]), 0);
    check("b2b_busy", 64'(busy_o[0]), 1);
    wait_done(0, ok);
    check("b2b_done", 64'(ok), 1);
    check("b2b_r", 64'(r_o[0]), 30);

    // reset mid-operation
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mrst_ready", 64'(ready_o[0]), 1);
    check("mrst_busy",  64'(busy_o[0]),  0);
    check("mrst_r",     64'(r_o[0]),     0);
    check("mrst_flags", 64'({cout_o[0], ovf_o[0], zero_o[0]}), 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o[0]) dcount++;
      @(posedge clk); #1;
    end
    check("mrst_nodone", 64'(dcount), 0);

    run_op(0, 0, 0, 32'h7FFFFFFF, 32'h1, lat);
    check("post_lat", 64'(lat), 33);
    check("post_r", 64'(r_o[0]), 64'h80000000);
    check("post_ovf", 64'(ovf_o[0]), 1);

    // wider digits
    run_op(1, 0, 1, 32'h12345678, 32'h11111111, lat);
    check("d8_lat",  64'(lat), 5);
    check("d8_r",    64'(r_o[1]), 64'h2345678A);
    check("d8_cout", 64'(cout_o[1]), 0);

    run_op(2, 0, 0, 32'hFFFFFFFF, 32'h1, lat);
    check("d32_lat",  64'(lat), 2);
    check("d32_r",    64'(r_o[2]), 0);
    check("d32_cout", 64'(cout_o[2]), 1);
    check("d32_zero", 64'(zero_o[2]), 1);

    run_op(2, 1, 0, 32'h80000000, 32'h1, lat);
    check("d32s_r",   64'(r_o[2]), 64'h7FFFFFFF);
    check("d32s_ovf", 64'(ovf_o[2]), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised, multi-cycle adder/subtractor for the ALU datapath. It processes DIGIT_W bits per clock over a WIDTH-bit operand, trading latency for area. Digits ripple through a chain of one-bit full_adder cells, and a registered carry links successive digits. Operation is controlled by a start/done handshake, and the block reports carry-out, signed overflow and a zero flag.

Parameters:
WIDTH, 32, operand/result width in bits
DIGIT_W, 1, bits processed per cycle; must divide WIDTH (elaboration error otherwise)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  request; accepted only when ready=1
ready  output  1  block can accept start
busy  output  1  computation in progress
sub  input  1  0: A+B+cin; 1: A-B (A+~B+1), cin ignored
cin  input  1  carry-in for add mode
A  input  WIDTH  operand, sampled on accepted start
B  input  WIDTH  operand, sampled on accepted start
r  output  WIDTH  result, valid from done until next accepted start
cout  output  1  carry-out of MSB (sub mode: 1 = no borrow)
overflow  output  1  signed two's-complement overflow
zero  output  1  r == 0
done  output  1  one-cycle pulse: result valid

Behaviour:
- Clock, reset and interface:
  - One clock (clk).
  - Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset (rst_n=0 at an edge), regardless of state:
  - state=IDLE.
  - r=0, cout=0, overflow=0, zero=0, done=0, busy=0, ready=1, digit counter=0.
  - Reset mid-operation aborts the operation and produces no done.
- N = WIDTH/DIGIT_W. States: IDLE, RUN, DONE.
- IDLE:
  - ready=1, busy=0.
  - start=1 at an edge: latch a_reg=A and b_reg=(sub ? ~B : B), and set carry=(sub ? 1 : cin).
  - Clear the counter; go to RUN.
- RUN:
  - ready=0, busy=1.
  - Each edge: digit i = bits [i*DIGIT_W +: DIGIT_W] is added with carry; write the sum into r_reg digit i and the digit carry-out into carry; i++.
  - Order is LSB digit first.
  - After the edge processing digit N-1: go to DONE, set cout=final carry, and update overflow and zero.
- start while busy: ignored with no side effect. Operands are not re-latched.
- Overflow = (a_reg[MSB] == b_reg[MSB]) && (r[MSB] != a_reg[MSB]), with b_reg being the post-inversion operand.
- DONE:
  - done=1 for exactly this one cycle; ready=1, busy=0.
  - Next edge: go to IDLE, or to RUN if start=1 (back-to-back operation, same latch rules as IDLE).
- Latency: start accepted at edge k → done high in the cycle after edge k+N. Throughput is one op per N+1 cycles.
- r/cout/overflow/zero:
  - Hold their last completed values in IDLE.
  - While RUN, r is not guaranteed stable; only read r, cout, overflow and zero when done=1 or afterward in IDLE.
  - For verification, the previous result is overwritten digit by digit during RUN.
- Wrap-around: the result is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
- N=1 (DIGIT_W=WIDTH) is legal: a single RUN cycle.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - counter-width helper constant CNT_W = clog2(N) (min 1)
- Sub-module adder_digit:
  - parameter DIGIT_W; ports a, b, cin, s, cout
  - purely combinational ripple chain generated from full_adder instances
- The top level holds the FSM, operand/result registers, counter and flag logic.

Test Plan:
- WIDTH=32, DIGIT_W=1, add A=0xFFFFFFFF, B=0x1, cin=0 → done exactly 33 cycles after the accepting edge; r=0, cout=1, zero=1, overflow=0.
- Sub A=5, B=7 → r=0xFFFFFFFE, cout=0, overflow=0, zero=0. Sub A=7, B=5 → r=2, cout=1.
- Add A=0x7FFFFFFF, B=1 → r=0x80000000, overflow=1, cout=0. Sub A=0x80000000, B=1 → r=0x7FFFFFFF, overflow=1, cout=1.
- Start A=3, B=4 add; pulse start with A=100, B=100 at RUN cycle 5 → ignored; done gives r=7; done pulse width exactly 1. Start held high during DONE → new op accepted back-to-back.
- rst_n=0 for one edge at RUN cycle 10 → next cycle ready=1, busy=0, r=0, flags 0, no done pulse. A new op afterwards completes correctly.
- WIDTH=32, DIGIT_W=8, add 0x12345678+0x11111111, cin=1 → done 5 cycles after acceptance, r=0x2345678A, cout=0. DIGIT_W=32: latency 2 cycles.
